lcd_msg_scheduler: RTL and testbench

- Shares the 16x2 character LCD between up to four message requesters (game FSM, score/timer, etc.) and drives the LCD driver's 4-bit message-select input.
- Requester 0 is the urgent source and preempts. Requesters 1..3 are served round-robin.
- Each granted message is held for a minimum display time, followed by a blank gap, so the LCD driver's continuous refresh loop shows every message.

---
 rtl/lcd_msg_scheduler_if.sv | 17 +
 rtl/lcd_msg_scheduler.sv | 92 +++++++++
 tb/tb_lcd_msg_scheduler.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_msg_scheduler_if.sv
// lcd_msg_scheduler_if: request/grant bundle between message requesters and the LCD scheduler
//   req        requester -> scheduler  request level per requester, held until acked
//   req_code   requester -> scheduler  4-bit message code per requester, nibble i for requester i
//   ack        scheduler -> requester  one-cycle one-hot grant pulse
//   lcd_code   scheduler -> LCD driver message select
//   busy       scheduler -> observers  high while a message or its trailing gap is on screen
//   active_id  scheduler -> observers  index of the requester currently shown
interface lcd_msg_scheduler_if;
   logic [3:0]  req;
   logic [15:0] req_code;
   logic [3:0]  ack;
   logic [3:0]  lcd_code;
   logic        busy;
   logic [1:0]  active_id;
   modport master (output req, req_code, input ack, lcd_code, busy, active_id);
   modport slave  (input req, req_code, output ack, lcd_code, busy, active_id);
endinterface

// File: rtl/lcd_msg_scheduler.sv
// lcd_msg_scheduler: shares the 16x2 LCD between four requesters (0 urgent/preempting, 1..3 round-robin)
//   clk_1MHz  system clock
//   rst       asynchronous active-high reset
//   bus_io    slave side of lcd_msg_scheduler_if (req/req_code in, ack/lcd_code/busy/active_id out)
module lcd_msg_scheduler #(
   parameter int         HOLD_CYCLES = 2000000,
   parameter int         GAP_CYCLES  = 100000,
   parameter logic [3:0] IDLE_CODE   = 4'b0000,
   parameter int         CNT_W       = 22
) (
   input  logic                 clk_1MHz,
   input  logic                 rst,
   lcd_msg_scheduler_if.slave   bus_io
);
   typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       rr_ptr_q, rr_ptr_d;
   logic [3:0]       ack_q, ack_d;
   logic [3:0]       lcd_code_q, lcd_code_d;
   logic             busy_q, busy_d;
   logic [1:0]       active_id_q, active_id_d;
   logic [1:0]       rr_p1, rr_p2, rr_id, gnt_id;
   logic             gnt;
   // round-robin successor within 1..3
   function automatic logic [1:0] nxt(input logic [1:0] p);
      return (p == 2'd3) ? 2'd1 : p + 2'd1;
   endfunction
   assign rr_p1  = nxt(rr_ptr_q);
   assign rr_p2  = nxt(rr_p1);
   assign rr_id  = bus_io.req[rr_ptr_q] ? rr_ptr_q : bus_io.req[rr_p1] ? rr_p1 : rr_p2;
   assign gnt_id = bus_io.req[0] ? 2'd0 : rr_id;
   // IDLE serves anyone; SHOW only lets 0 preempt someone else; GAP only lets 0 in early
   assign gnt = (state_q == IDLE) ? |bus_io.req :
                (state_q == SHOW) ? (bus_io.req[0] && active_id_q != 2'd0) :
                (state_q == GAP)  ? bus_io.req[0] : 1'b0;
   always_ff @(posedge clk_1MHz or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rr_ptr_q    <= 2'd1;
         ack_q       <= '0;
         lcd_code_q  <= IDLE_CODE;
         busy_q      <= 1'b0;
         active_id_q <= 2'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         ack_q       <= ack_d;
         lcd_code_q  <= lcd_code_d;
         busy_q      <= busy_d;
         active_id_q <= active_id_d;
      end
   end
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rr_ptr_d    = rr_ptr_q;
      ack_d       = '0;
      lcd_code_d  = lcd_code_q;
      busy_d      = busy_q;
      active_id_d = active_id_q;
      if (gnt) begin
         state_d     = SHOW;
         cnt_d       = '0;
         ack_d       = 4'b0001 << gnt_id;
         lcd_code_d  = bus_io.req_code[{gnt_id, 2'b00} +: 4];
         busy_d      = 1'b1;
         active_id_d = gnt_id;
         if (gnt_id != 2'd0) rr_ptr_d = nxt(gnt_id);
      end else if (state_q == SHOW) begin
         if (cnt_q == HOLD_LAST) begin
            state_d    = GAP;
            cnt_d      = '0;
            lcd_code_d = IDLE_CODE;
         end else cnt_d = cnt_q + 1'b1;
      end else if (state_q == GAP) begin
         if (cnt_q == GAP_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end else cnt_d = cnt_q + 1'b1;
      end
   end
   assign bus_io.ack       = ack_q;
   assign bus_io.lcd_code  = lcd_code_q;
   assign bus_io.busy      = busy_q;
   assign bus_io.active_id = active_id_q;
endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// tb_lcd_msg_scheduler: directed bench for lcd_msg_scheduler with a grant scoreboard
module tb_lcd_msg_scheduler;
   logic clk_1MHz = 1'b0;
   logic rst = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;
   typedef struct { logic [1:0] id; logic [3:0] code; } exp_t;
   exp_t sb[$];
   logic [3:0] prev_ack = '0;
   lcd_msg_scheduler_if bus ();
   lcd_msg_scheduler #(.HOLD_CYCLES(10), .GAP_CYCLES(3), .IDLE_CODE(4'h0), .CNT_W(4)) dut (
      .clk_1MHz(clk_1MHz),
      .rst(rst),
      .bus_io(bus.slave)
   );
   always #5 clk_1MHz = ~clk_1MHz;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clk_1MHz);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask
   task automatic expect_grant(input logic [1:0] id, input logic [3:0] code);
      exp_t e;
      e.id = id;
      e.code = code;
      sb.push_back(e);
   endtask
   // scoreboard: every ack must match the oldest expected grant
   always @(posedge clk_1MHz) begin
      #1;
      if (bus.ack != 4'b0000) begin
         check("ack_onehot", 32'($onehot(bus.ack)), 32'd1);
         check("ack_repeat", 32'(bus.ack & prev_ack), 32'd0);
         if (sb.size() == 0) check("unexpected_ack", 32'(bus.ack), 32'd0);
         else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_ack", 32'(bus.ack), 32'(4'b0001 << e.id));
            check("sb_code", 32'(bus.lcd_code), 32'(e.code));
            check("sb_id", 32'(bus.active_id), 32'(e.id));
         end
      end
      prev_ack = bus.ack;
   end
   initial begin
      int seq[4] = '{1, 2, 3, 1};
      bus.req = '0;
      bus.req_code = '0;
      #1 rst = 1'b1;
      #2;
      check("rst_lcd", 32'(bus.lcd_code), 32'h0);
      check("rst_ack", 32'(bus.ack), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_id", 32'(bus.active_id), 32'h0);
      #3 rst = 1'b0;
      step(1);
      // single request: hold then gap
      bus.req = 4'b0010;
      bus.req_code = 16'h0010;
      expect_grant(2'd1, 4'h1);
      step(1);
      check("t1_ack", 32'(bus.ack), 32'b0010);
      check("t1_lcd", 32'(bus.lcd_code), 32'h1);
      check("t1_id", 32'(bus.active_id), 32'd1);
      check("t1_busy", 32'(bus.busy), 32'd1);
      bus.req = '0;
      step(9);
      check("t1_hold", 32'(bus.lcd_code), 32'h1);
      step(1);
      check("t1_blank", 32'(bus.lcd_code), 32'h0);
      step(2);
      check("t1_gap_busy", 32'(bus.busy), 32'd1);
      step(1);
      check("t1_idle_busy", 32'(bus.busy), 32'd0);
      // round robin among 1..3
      do_reset();
      bus.req = 4'b1110;
      bus.req_code = 16'h3210;
      for (int k = 0; k < 4; k++) begin
         expect_grant(2'(seq[k]), 4'(seq[k]));
         step(1);
         check("t2_ack", 32'(bus.ack), 32'(4'b0001 << seq[k]));
         check("t2_lcd", 32'(bus.lcd_code), 32'(seq[k]));
         bus.req[seq[k]] = 1'b0;
         step(9);
         check("t2_hold", 32'(bus.lcd_code), 32'(seq[k]));
         step(1);
         check("t2_blank", 32'(bus.lcd_code), 32'h0);
         step(3);
         check("t2_idle", 32'(bus.busy), 32'd0);
         if (k < 3) bus.req[seq[k]] = 1'b1;
      end
      bus.req = '0;
      // preemption of requester 2 by requester 0
      do_reset();
      bus.req = 4'b0100;
      bus.req_code = 16'h0500;
      expect_grant(2'd2, 4'h5);
      step(1);
      check("t3_id2", 32'(bus.active_id), 32'd2);
      bus.req = '0;
      step(4);
      bus.req = 4'b0001;
      bus.req_code[3:0] = 4'h2;
      expect_grant(2'd0, 4'h2);
      step(1);
      check("t3_ack", 32'(bus.ack), 32'b0001);
      check("t3_lcd", 32'(bus.lcd_code), 32'h2);
      check("t3_id0", 32'(bus.active_id), 32'd0);
      bus.req = '0;
      step(9);
      check("t3_hold", 32'(bus.lcd_code), 32'h2);
      step(1);
      check("t3_blank", 32'(bus.lcd_code), 32'h0);
      // requester 0 during gap, then while already showing 0
      bus.req = 4'b0001;
      bus.req_code[3:0] = 4'h7;
      expect_grant(2'd0, 4'h7);
      step(1);
      check("t4_gap_ack", 32'(bus.ack), 32'b0001);
      check("t4_gap_lcd", 32'(bus.lcd_code), 32'h7);
      check("t4_gap_busy", 32'(bus.busy), 32'd1);
      bus.req_code[3:0] = 4'h9;
      expect_grant(2'd0, 4'h9);
      for (int i = 0; i < 10; i++) begin
         step(1);
         check("t4_no_ack", 32'(bus.ack), 32'h0);
      end
      check("t4_blank", 32'(bus.lcd_code), 32'h0);
      step(1);
      check("t4_regrant", 32'(bus.ack), 32'b0001);
      check("t4_regrant_lcd", 32'(bus.lcd_code), 32'h9);
      bus.req = '0;
      // asynchronous reset mid-show
      do_reset();
      bus.req = 4'b0010;
      bus.req_code = 16'h3010;
      expect_grant(2'd1, 4'h1);
      step(1);
      bus.req = '0;
      step(6);
      rst = 1'b1;
      #1;
      check("t5_lcd", 32'(bus.lcd_code), 32'h0);
      check("t5_ack", 32'(bus.ack), 32'h0);
      check("t5_busy", 32'(bus.busy), 32'd0);
      check("t5_id", 32'(bus.active_id), 32'd0);
      #1 rst = 1'b0;
      bus.req = 4'b1000;
      expect_grant(2'd3, 4'h3);
      step(1);
      check("t5_ack3", 32'(bus.ack), 32'b1000);
      check("t5_id3", 32'(bus.active_id), 32'd3);
      bus.req = '0;
      step(13);
      check("t5_idle", 32'(bus.busy), 32'd0);
      bus.req = 4'b1010;
      expect_grant(2'd1, 4'h1);
      step(1);
      check("t5_rr_wrap", 32'(bus.ack), 32'b0010);
      bus.req = '0;
      // short request during show is lost
      do_reset();
      bus.req = 4'b0100;
      bus.req_code = 16'h0510;
      expect_grant(2'd2, 4'h5);
      step(1);
      bus.req = '0;
      step(3);
      bus.req = 4'b0010;
      step(1);
      bus.req = '0;
      step(9);
      check("t6_idle_busy", 32'(bus.busy), 32'd0);
      check("t6_idle_lcd", 32'(bus.lcd_code), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("t6_stay_busy", 32'(bus.busy), 32'd0);
         check("t6_stay_lcd", 32'(bus.lcd_code), 32'h0);
         check("t6_stay_ack", 32'(bus.ack), 32'h0);
      end
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
